// File: rtl/mulalu_if.sv
// mulalu_if -- pipeline/unit signal bundle for the multiply/divide controller. Rev 1.0
`default_nettype none

interface mulalu_if;
  logic reg_stall;
  logic reg_flush;
  logic op_valid;
  logic op_div;
  logic op_sign;
  logic divisor_zero;
  logic mul_start;
  logic div_start;
  logic unit_sign;
  logic unit_abort;
  logic hilo_we;
  logic alu_stall;
  logic busy;

  modport slave (
    input  reg_stall, reg_flush, op_valid, op_div, op_sign, divisor_zero,
    output mul_start, div_start, unit_sign, unit_abort, hilo_we, alu_stall, busy
  );

  modport master (
    output reg_stall, reg_flush, op_valid, op_div, op_sign, divisor_zero,
    input  mul_start, div_start, unit_sign, unit_abort, hilo_we, alu_stall, busy
  );
endinterface

`default_nettype wire

// File: rtl/mulalu_ctrl.sv
// mulalu_ctrl -- sequences multiplier/divider ops, EX-stage stall and HI/LO write. Rev 1.0
`default_nettype none

module mulalu_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic     clk,
  input  logic     rst,
  mulalu_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] C_MUL_LD = 6'(MUL_LAT - 1);
  localparam logic [5:0] C_DIV_LD = 6'(DIV_LAT - 1);

  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       sign_q, sign_d;
  logic       div_q, div_d;

  logic w_mul_start;
  logic w_div_start;
  logic w_abort;
  logic w_hilo_we;
  logic w_alu_stall;
  logic w_unit_sign;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    div_d       = div_q;
    w_mul_start = 1'b0;
    w_div_start = 1'b0;
    w_abort     = 1'b0;
    w_hilo_we   = 1'b0;
    w_alu_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.reg_flush && bus.op_valid) begin
          w_alu_stall = 1'b1;
          sign_d      = bus.op_sign;
          div_d       = bus.op_div;
          // Divide by zero never touches the divider; HI/LO stay as they are.
          if (bus.op_div && bus.divisor_zero) begin
            state_d = S_DONE;
          end else begin
            w_mul_start = !bus.op_div;
            w_div_start = bus.op_div;
            cnt_d       = bus.op_div ? C_DIV_LD : C_MUL_LD;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.reg_flush) begin
          w_abort = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q != 6'd0) begin
          w_alu_stall = 1'b1;
          cnt_d       = cnt_q - 6'd1;
        end else begin
          w_hilo_we = 1'b1;
          state_d   = bus.reg_stall ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        // Same instruction still sits in EX; wait for it to leave before re-arming.
        if (bus.reg_flush || !bus.reg_stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      sign_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      div_q   <= div_d;
    end
  end

  assign w_unit_sign = (w_mul_start || w_div_start) ? bus.op_sign : sign_q;

  // Outputs gated by reset so they drop the instant reset asserts.
  assign bus.mul_start  = rst & w_mul_start;
  assign bus.div_start  = rst & w_div_start;
  assign bus.unit_sign  = rst & w_unit_sign;
  assign bus.unit_abort = rst & w_abort;
  assign bus.hilo_we    = rst & w_hilo_we;
  assign bus.alu_stall  = rst & w_alu_stall;
  assign bus.busy       = rst & (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mulalu_ctrl.sv
// tb_mulalu_ctrl -- directed cycle-by-cycle bench for mulalu_ctrl. Rev 1.0
`default_nettype none

module tb_mulalu_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  mulalu_if bus ();

  mulalu_ctrl #(.MUL_LAT(2), .DIV_LAT(33)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: mul_start, div_start, unit_sign, unit_abort, hilo_we, alu_stall, busy
  localparam logic [6:0] C_ALL     = 7'b1111111;
  localparam logic [6:0] C_NO_SIGN = 7'b1101111;

  function automatic logic [6:0] obs();
    return {bus.mul_start, bus.div_start, bus.unit_sign, bus.unit_abort,
            bus.hilo_we, bus.alu_stall, bus.busy};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.reg_stall    = 1'b0;
    bus.reg_flush    = 1'b0;
    bus.op_valid     = 1'b0;
    bus.op_div       = 1'b0;
    bus.op_sign      = 1'b0;
    bus.divisor_zero = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.op_valid = 1'b1;
    #3;
    checks++;
    if (obs() !== 7'b0) $display("FAIL reset_hold: got %b want %b", obs(), 7'b0);
    else passes++;
    bus.op_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 7'b0) $display("FAIL reset_release: got %b want %b", obs(), 7'b0);
    else passes++;
  endtask

  task automatic run_mul(input string name, input logic sgn);
    logic [6:0] e, m;
    for (int c = 0; c <= 3; c++) begin
      next_cycle();
      bus.op_valid = (c <= 2);
      bus.op_div   = 1'b0;
      bus.op_sign  = sgn;
      @(negedge clk);
      m = C_ALL;
      case (c)
        0:       e = {1'b1, 1'b0, sgn, 4'b0010};
        1:       e = {1'b0, 1'b0, sgn, 4'b0011};
        2:       e = {1'b0, 1'b0, sgn, 4'b0101};
        default: begin e = 7'b0; m = C_NO_SIGN; end
      endcase
      checks++;
      if ((obs() & m) !== (e & m)) $display("FAIL %s cyc %0d: got %b want %b", name, c, obs(), e);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_mul();
    run_mul("mul_signed", 1'b1);
  endtask

  task automatic test_div();
    logic [6:0] e, m;
    for (int c = 0; c <= 34; c++) begin
      next_cycle();
      bus.op_valid = (c <= 33);
      bus.op_div   = 1'b1;
      bus.op_sign  = 1'b1;
      @(negedge clk);
      m = C_ALL;
      if (c == 0)       e = 7'b0110010;
      else if (c <= 32) e = 7'b0010011;
      else if (c == 33) e = 7'b0010101;
      else begin e = 7'b0; m = C_NO_SIGN; end
      checks++;
      if ((obs() & m) !== (e & m)) $display("FAIL div cyc %0d: got %b want %b", c, obs(), e);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_divzero();
    logic [6:0] e;
    for (int c = 0; c <= 2; c++) begin
      next_cycle();
      bus.op_valid     = (c <= 1);
      bus.op_div       = 1'b1;
      bus.divisor_zero = 1'b1;
      @(negedge clk);
      case (c)
        0:       e = 7'b0000010;
        1:       e = 7'b0000001;
        default: e = 7'b0;
      endcase
      checks++;
      if ((obs() & C_NO_SIGN) !== e) $display("FAIL divzero cyc %0d: got %b want %b", c, obs(), e);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [6:0] e;
    for (int c = 0; c <= 6; c++) begin
      next_cycle();
      bus.op_valid  = (c <= 5);
      bus.reg_stall = (c >= 1 && c <= 4);
      @(negedge clk);
      case (c)
        0:       e = 7'b1000010;
        1:       e = 7'b0000011;
        2:       e = 7'b0000101;
        3, 4, 5: e = 7'b0000001;
        default: e = 7'b0;
      endcase
      checks++;
      if (obs() !== e) $display("FAIL stall cyc %0d: got %b want %b", c, obs(), e);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_flush(input int f);
    logic [6:0] e;
    for (int c = 0; c <= f + 2; c++) begin
      next_cycle();
      bus.op_valid  = (c <= f);
      bus.op_div    = 1'b1;
      bus.reg_flush = (c == f);
      @(negedge clk);
      if (c == 0)     e = 7'b0100010;
      else if (c < f) e = 7'b0000011;
      else if (c == f) e = 7'b0001001;
      else            e = 7'b0;
      checks++;
      if ((obs() & C_NO_SIGN) !== e) $display("FAIL flush%0d cyc %0d: got %b want %b", f, c, obs(), e);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    for (int c = 0; c <= 7; c++) begin
      next_cycle();
      bus.op_valid  = (c <= 6);
      bus.reg_flush = (c == 6);
      @(negedge clk);
      case (c)
        0, 3:    e = 7'b1000010;
        1, 4:    e = 7'b0000011;
        2, 5:    e = 7'b0000101;
        default: e = 7'b0;
      endcase
      checks++;
      if (obs() !== e) $display("FAIL b2b cyc %0d: got %b want %b", c, obs(), e);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      bus.op_valid = 1'b1;
      bus.op_div   = 1'b1;
    end
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 7'b0) $display("FAIL rst_mid_async: got %b want %b", obs(), 7'b0);
    else passes++;
    next_cycle();
    checks++;
    if (obs() !== 7'b0) $display("FAIL rst_mid_held: got %b want %b", obs(), 7'b0);
    else passes++;
    idle_inputs();
    rst = 1'b1;
    run_mul("mul_after_rst", 1'b1);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_stall();
    test_flush(10);
    test_flush(33);
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passes %0d", checks, passes);
    $fatal(1);
  end

endmodule

`default_nettype wire
